multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore FSM control unit for the multi-cycle MIPS datapath. Successor to the single-cycle decoder.
- Sequences fetch, decode, execute, memory and write-back over several cycles. Drives all datapath mux selects and enables from the current state only.
- Adds a memory-ready handshake, optional immediate-ALU and bne support, and a sticky illegal-opcode trap.

Parameters:
- OPCODE_W, 6, opcode field width.
- SUPPORT_IMM, 1, enables addi/andi/ori (opcodes 001000/001100/001101); when 0 these opcodes trap.
- SUPPORT_BNE, 1, enables bne (000101); when 0 it traps.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  OPCODE_W  instruction register bits [31:26]; sampled only in DECODE
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_write  output  1  unconditional PC update
- pc_write_cond  output  1  PC update gated by the branch condition
- branch_ne  output  1  1 = branch condition is !zero (bne); 0 = zero (beq)
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  write-back data select: 1 = MDR
- reg_dst  output  1  destination select: 1 = rd, 0 = rt
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = immediate-op decoded by ALU control
- imm_logic  output  2  with alu_op = 11: 00 = add, 01 = and, 10 = or
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  sticky trap flag
- state_o  output  4  current state encoding, for debug

Behaviour:
- States (4-bit encoding): FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, IEXEC = 10, IWB = 11, TRAP = 15.
- Reset: rst_n low asynchronously forces state to FETCH, clears illegal_op and clears the latched imm_logic.
- Outputs are purely combinational from state (Moore), plus mem_ready gating where stated. Every output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target precompute).
  - Next state by opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 000101 with SUPPORT_BNE → BRANCH, with branch_ne latched to 1
    - 000010 → JUMP
    - supported immediate opcode → IEXEC, with imm_logic latched
    - anything else → TRAP
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to MEMRD for lw, MEMWR for sw; this uses an opcode latched in DECODE, not the live input.
- MEMRD: mem_read = 1, i_or_d = 1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Go to FETCH.
- MEMWR: mem_write = 1, i_or_d = 1. Hold until mem_ready, then go to FETCH. mem_write stays high for the whole hold.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Go to RWB.
- RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Go to FETCH.
- IEXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 11, imm_logic = latched value. Go to IWB.
- IWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Go to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01, branch_ne = latched value. Go to FETCH. The branch_ne latch clears on FETCH entry.
- JUMP: pc_write = 1, pc_source = 10. Go to FETCH.
- TRAP: illegal_op = 1, all enables 0. Absorbing state; only reset exits.
- Cycle counts with mem_ready tied high: R-type 4, lw 5, sw 4, beq/bne 3, j 3, imm 4. Each memory wait cycle adds 1.
- No enable output (reg_write, mem_write, pc_write, pc_write_cond, ir_write) ever carries X. Don't-care selects drive 0.
- Reset mid-instruction: any state returns to FETCH immediately; no partial write is issued after the reset release edge.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI);
  - state enum/encodings;
  - alu_op, alu_src_b and pc_source encodings.
- One sub-module, mcu_output_decode: a purely combinational map from state plus latched flags to control outputs. The FSM register/next-state logic stays in the top.

Test Plan:
- R-type, opcode 000000, mem_ready = 1 → state sequence 0,1,6,7,0; reg_write = 1 and reg_dst = 1 only in state 7.
- lw, opcode 100011, mem_ready low for 2 cycles in MEMRD → state sequence 0,1,2,3,3,3,4,0; mem_read held high in state 3; reg_write = 1 and mem_to_reg = 1 in state 4.
- sw followed by bne (SUPPORT_BNE = 1) → sw: mem_write high exactly 1 cycle in state 5. bne: state 8 with pc_write_cond = 1, branch_ne = 1, alu_op = 01.
- Opcode 111111 in DECODE → state 15 on the next edge, illegal_op = 1 held for 10 cycles. rst_n pulse → state 0, illegal_op = 0.
- SUPPORT_IMM = 0, opcode 001000 → TRAP. SUPPORT_IMM = 1, ori 001101 → IEXEC with alu_op = 11 and imm_logic = 10, then IWB with reg_write = 1.
- rst_n asserted asynchronously mid-MEMWR with mem_ready = 0 → mem_write drops without waiting for a clock edge; state = 0 after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states,
// datapath select codes and the bundled control-output word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd15;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] IMM_ADD = 2'b00;
  localparam logic [1:0] IMM_AND = 2'b01;
  localparam logic [1:0] IMM_OR  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_logic;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: opcode/mem_ready into the FSM, mux selects
// and enables out. master = control unit, slave = datapath side.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                branch_ne;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          imm_logic;
  logic [1:0]          pc_source;
  logic                illegal_op;
  logic [3:0]          state_o;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, imm_logic, pc_source, illegal_op, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, imm_logic, pc_source, illegal_op, state_o
  );
endinterface

// File: rtl/mcu_output_decode.sv
// Moore output map: state plus latched branch/imm flags -> control word, no state.
// Zero latency; mem_ready only gates the FETCH-cycle IR/PC load.
module mcu_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  input  logic       i_branch_ne,
  input  logic [1:0] i_imm_logic,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      // Branch target is precomputed into ALUOut while the opcode is decoded.
      S_DECODE: o_ctrl.alu_src_b = SRCB_IMMSH2;
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_IMM;
        o_ctrl.imm_logic = i_imm_logic;
      end
      S_IWB: o_ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.branch_ne     = i_branch_ne;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and DECODE-time latches.
// 3-5 cycles per instruction; MEMRD/MEMWR/FETCH hold while mem_ready is low.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int SUPPORT_IMM = 1,
  parameter int SUPPORT_BNE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  multicycle_control_unit_if.master    bus
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_dec_next;
  logic [1:0] w_dec_imm;
  logic       r_is_sw;
  logic       r_branch_ne;
  logic [1:0] r_imm_logic;
  logic       r_illegal;
  ctrl_t      w_ctrl;

  always_comb begin
    w_dec_next = S_TRAP;
    w_dec_imm  = IMM_ADD;
    case (bus.opcode)
      OPCODE_W'(OP_RTYPE):          w_dec_next = S_EXEC;
      OPCODE_W'(OP_LW),
      OPCODE_W'(OP_SW):             w_dec_next = S_MEMADR;
      OPCODE_W'(OP_BEQ):            w_dec_next = S_BRANCH;
      OPCODE_W'(OP_BNE):  if (SUPPORT_BNE != 0) w_dec_next = S_BRANCH;
      OPCODE_W'(OP_J):              w_dec_next = S_JUMP;
      OPCODE_W'(OP_ADDI): if (SUPPORT_IMM != 0) w_dec_next = S_IEXEC;
      OPCODE_W'(OP_ANDI): if (SUPPORT_IMM != 0) begin
        w_dec_next = S_IEXEC;
        w_dec_imm  = IMM_AND;
      end
      OPCODE_W'(OP_ORI):  if (SUPPORT_IMM != 0) begin
        w_dec_next = S_IEXEC;
        w_dec_imm  = IMM_OR;
      end
      default: w_dec_next = S_TRAP;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = w_dec_next;
      S_MEMADR: w_next = r_is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
      S_EXEC:   w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_IEXEC:  w_next = S_IWB;
      S_IWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      // Unused encodings are treated as corruption and trapped.
      default:  w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_is_sw     <= 1'b0;
      r_branch_ne <= 1'b0;
      r_imm_logic <= IMM_ADD;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_next;
      // MEMADR must steer on the opcode seen in DECODE, not whatever the IR shows later.
      if (r_state == S_DECODE) begin
        r_is_sw     <= (bus.opcode == OPCODE_W'(OP_SW));
        r_branch_ne <= (SUPPORT_BNE != 0) && (bus.opcode == OPCODE_W'(OP_BNE));
        r_imm_logic <= w_dec_imm;
      end else if (w_next == S_FETCH) begin
        r_branch_ne <= 1'b0;
      end
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  mcu_output_decode u_output_decode (
    .i_state     (r_state),
    .i_mem_ready (bus.mem_ready),
    .i_branch_ne (r_branch_ne),
    .i_imm_logic (r_imm_logic),
    .o_ctrl      (w_ctrl)
  );

  assign bus.pc_write      = w_ctrl.pc_write;
  assign bus.pc_write_cond = w_ctrl.pc_write_cond;
  assign bus.branch_ne     = w_ctrl.branch_ne;
  assign bus.i_or_d        = w_ctrl.i_or_d;
  assign bus.mem_read      = w_ctrl.mem_read;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.ir_write      = w_ctrl.ir_write;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.reg_dst       = w_ctrl.reg_dst;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.imm_logic     = w_ctrl.imm_logic;
  assign bus.pc_source     = w_ctrl.pc_source;
  assign bus.illegal_op    = r_illegal;
  assign bus.state_o       = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: stimulus pushes expected state/controls per cycle, a negedge monitor compares.
// A second instance with SUPPORT_IMM = SUPPORT_BNE = 0 shares clock, reset and inputs.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcw, pcwc, bne, iord, mr, mw, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aop, imm, pcs;
    logic       ill;
  } obs_t;

  typedef struct packed {
    logic [3:0] st;
    obs_t       o;
  } rec_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000,
                         ANDI = 6'b001100, ORI = 6'b001101, RTY = 6'b000000;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  rec_t q[$];
  rec_t q0[$];

  multicycle_control_unit_if #(.OPCODE_W(6)) bus ();
  multicycle_control_unit_if #(.OPCODE_W(6)) bus0 ();

  multicycle_control_unit #(.OPCODE_W(6), .SUPPORT_IMM(1), .SUPPORT_BNE(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  multicycle_control_unit #(.OPCODE_W(6), .SUPPORT_IMM(0), .SUPPORT_BNE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  obs_t obs, obs0;
  assign obs  = {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.i_or_d, bus.mem_read,
                 bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                 bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_logic, bus.pc_source,
                 bus.illegal_op};
  assign obs0 = {bus0.pc_write, bus0.pc_write_cond, bus0.branch_ne, bus0.i_or_d, bus0.mem_read,
                 bus0.mem_write, bus0.ir_write, bus0.mem_to_reg, bus0.reg_dst, bus0.reg_write,
                 bus0.alu_src_a, bus0.alu_src_b, bus0.alu_op, bus0.imm_logic, bus0.pc_source,
                 bus0.illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t exp_obs(logic [3:0] st, logic rdy, logic bne, logic [1:0] imm);
    obs_t e;
    e = '0;
    case (st)
      4'd0:  begin e.mr = 1'b1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      4'd1:  e.srcb = 2'b11;
      4'd2:  begin e.srca = 1'b1; e.srcb = 2'b10; end
      4'd3:  begin e.mr = 1'b1; e.iord = 1'b1; end
      4'd4:  begin e.rw = 1'b1; e.m2r = 1'b1; end
      4'd5:  begin e.mw = 1'b1; e.iord = 1'b1; end
      4'd6:  begin e.srca = 1'b1; e.aop = 2'b10; end
      4'd7:  begin e.rw = 1'b1; e.rdst = 1'b1; end
      4'd8:  begin e.srca = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.pcs = 2'b01; e.bne = bne; end
      4'd9:  begin e.pcw = 1'b1; e.pcs = 2'b10; end
      4'd10: begin e.srca = 1'b1; e.srcb = 2'b10; e.aop = 2'b11; e.imm = imm; end
      4'd11: e.rw = 1'b1;
      4'd15: e.ill = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  // One clock cycle: drive inputs, queue what both instances must show, advance.
  task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                      input logic bne = 1'b0, input logic [1:0] imm = 2'b00,
                      input logic c0 = 1'b0, input logic [3:0] st0 = 4'd0);
    bus.opcode     = op;
    bus.mem_ready  = rdy;
    bus0.opcode    = op;
    bus0.mem_ready = rdy;
    q.push_back({st, exp_obs(st, rdy, bne, imm)});
    if (c0) q0.push_back({st0, exp_obs(st0, rdy, 1'b0, 2'b00)});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if ({bus.state_o, obs} !== e) begin
        n_bad++;
        $display("FAIL dut t=%0t: state got %0d want %0d, ctl got %h want %h",
                 $time, bus.state_o, e.st, obs, e.o);
      end
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      n_vec++;
      if ({bus0.state_o, obs0} !== e) begin
        n_bad++;
        $display("FAIL dut0 t=%0t: state got %0d want %0d, ctl got %h want %h",
                 $time, bus0.state_o, e.st, obs0, e.o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    bus.opcode = '0; bus.mem_ready = 1'b0;
    bus0.opcode = '0; bus0.mem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, FETCH holds without mem_ready.
    step(RTY, 1'b0, 4'd0, .c0(1'b1), .st0(4'd0));
    step(RTY, 1'b0, 4'd0);
    // R-type: 0,1,6,7
    step(RTY, 1'b1, 4'd0);
    step(RTY, 1'b1, 4'd1);
    step(RTY, 1'b1, 4'd6);
    step(RTY, 1'b1, 4'd7);
    // lw with two wait cycles; live opcode changed to sw after DECODE.
    step(RTY, 1'b1, 4'd0);
    step(LW,  1'b1, 4'd1);
    step(SW,  1'b1, 4'd2);
    step(SW,  1'b0, 4'd3);
    step(SW,  1'b0, 4'd3);
    step(SW,  1'b1, 4'd3);
    step(SW,  1'b1, 4'd4);
    // sw (live opcode changed to lw after DECODE), then bne.
    step(RTY, 1'b1, 4'd0);
    step(SW,  1'b1, 4'd1);
    step(LW,  1'b1, 4'd2);
    step(LW,  1'b1, 4'd5);
    step(RTY, 1'b1, 4'd0);
    step(BNE, 1'b1, 4'd1);
    step(RTY, 1'b1, 4'd8, .bne(1'b1));
    // beq right after bne: latch must have cleared.
    step(RTY, 1'b1, 4'd0);
    step(BEQ, 1'b1, 4'd1);
    step(RTY, 1'b1, 4'd8, .bne(1'b0));
    // jump
    step(RTY, 1'b1, 4'd0);
    step(JMP, 1'b1, 4'd1);
    step(RTY, 1'b1, 4'd9);
    // addi, andi
    step(RTY,  1'b1, 4'd0);
    step(ADDI, 1'b1, 4'd1);
    step(RTY,  1'b1, 4'd10, .imm(2'b00));
    step(RTY,  1'b1, 4'd11);
    step(RTY,  1'b1, 4'd0);
    step(ANDI, 1'b1, 4'd1);
    step(RTY,  1'b1, 4'd10, .imm(2'b01));
    step(RTY,  1'b1, 4'd11);
    // Illegal opcode: absorbing TRAP for 10 cycles regardless of inputs.
    step(RTY,   1'b1, 4'd0);
    step(6'h3F, 1'b1, 4'd1);
    for (int i = 0; i < 10; i++) step(6'($urandom_range(0, 63)), 1'(i & 1), 4'd15);
    rst_n = 1'b0;
    #1;
    check("trap_reset_state", 8'(bus.state_o), 8'd0);
    check("trap_reset_illegal", 8'(bus.illegal_op), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Feature-disabled instance traps on addi/ori/bne; full instance executes them.
    step(RTY,  1'b1, 4'd0, .c0(1'b1), .st0(4'd0));
    step(ADDI, 1'b1, 4'd1, .c0(1'b1), .st0(4'd1));
    step(RTY,  1'b1, 4'd10, .imm(2'b00), .c0(1'b1), .st0(4'd15));
    step(RTY,  1'b1, 4'd11, .c0(1'b1), .st0(4'd15));
    do_reset();
    step(RTY, 1'b1, 4'd0, .c0(1'b1), .st0(4'd0));
    step(ORI, 1'b1, 4'd1, .c0(1'b1), .st0(4'd1));
    step(RTY, 1'b1, 4'd10, .imm(2'b10), .c0(1'b1), .st0(4'd15));
    step(RTY, 1'b1, 4'd11, .c0(1'b1), .st0(4'd15));
    step(RTY, 1'b1, 4'd0);
    do_reset();
    step(RTY, 1'b1, 4'd0, .c0(1'b1), .st0(4'd0));
    step(BNE, 1'b1, 4'd1, .c0(1'b1), .st0(4'd1));
    step(RTY, 1'b1, 4'd8, .bne(1'b1), .c0(1'b1), .st0(4'd15));

    // Async reset in the middle of a stalled MEMWR.
    do_reset();
    step(RTY, 1'b1, 4'd0);
    step(SW,  1'b1, 4'd1);
    step(SW,  1'b0, 4'd2);
    step(SW,  1'b0, 4'd5);
    #2;
    check("memwr_hold_write", 8'(bus.mem_write), 8'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_write", 8'(bus.mem_write), 8'd0);
    check("async_rst_state", 8'(bus.state_o), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(SW, 1'b0, 4'd0);
    step(SW, 1'b1, 4'd0);
    step(SW, 1'b1, 4'd1);

    @(negedge clk);
    #1;
    check("queues_drained", 8'(q.size() + q0.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
